// File: rtl/double_buffer_reader.sv
// Drains the filled half of the ping-pong sample buffer over a 1-cycle-latency
// read port and emits it as a valid/ready stream with last flag and buffer ID.
module double_buffer_reader #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SAMPLES_PER_BUF = 256,
  parameter int unsigned ADDR_WIDTH      = $clog2(SAMPLES_PER_BUF),
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned OVR_CNT_WIDTH   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     buf_ready_pulse_i,
  input  logic                     buf_ready_id_i,
  output logic [ADDR_WIDTH-1:0]    rd_addr_o,
  output logic                     rd_en_o,
  input  logic [DATA_WIDTH-1:0]    rd_data_i,
  input  logic                     rd_data_valid_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic                     out_last_o,
  output logic                     out_buf_id_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     overrun_o,
  output logic [OVR_CNT_WIDTH-1:0] overrun_cnt_o,
  input  logic                     clr_overrun_i
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SAMPLES_PER_BUF - 1);
  localparam logic [PTR_W-1:0]      PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic                     buf_id_q, buf_id_d;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic                     frame_done_q;
  logic                     overrun_q, overrun_d;
  logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

  logic [DATA_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];
  logic                     fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         fifo_cnt_q;

  logic                     pop_c, push_c, head_last_c, last_hs_c;
  logic                     room_c, rd_en_c, accept_c, drop_c;
  logic [CNT_W:0]           occ_c;

  // Issue a read only if the word will still fit once it lands, counting the
  // word already in flight and any beat leaving this cycle.
  always_comb begin
    pop_c       = (fifo_cnt_q != '0) && out_ready_i;
    push_c      = rd_data_valid_i && inflight_q;
    head_last_c = fifo_last_q[rd_ptr_q];
    last_hs_c   = pop_c && head_last_c;
    occ_c       = (CNT_W+1)'(fifo_cnt_q) + (CNT_W+1)'(inflight_q);
    room_c      = occ_c < ((CNT_W+1)'(FIFO_DEPTH) + (CNT_W+1)'(pop_c));
    rd_en_c     = (state_q == ST_READ) && room_c;
    accept_c    = buf_ready_pulse_i &&
                  ((state_q == ST_IDLE) || ((state_q == ST_DRAIN) && last_hs_c));
    drop_c      = buf_ready_pulse_i && !accept_c;
  end

  // Frame sequencing
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    buf_id_d  = buf_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_READ;
          rd_addr_d = '0;
          buf_id_d  = buf_ready_id_i;
        end
      end
      ST_READ: begin
        if (rd_en_c) begin
          if (rd_addr_q == LAST_ADDR) begin
            state_d   = ST_DRAIN;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (last_hs_c) begin
          if (accept_c) begin
            state_d   = ST_READ;
            rd_addr_d = '0;
            buf_id_d  = buf_ready_id_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overrun flag and saturating drop counter; clear wins over a same-cycle drop
  always_comb begin
    overrun_d = overrun_q;
    ovr_cnt_d = ovr_cnt_q;
    if (clr_overrun_i) begin
      overrun_d = 1'b0;
      ovr_cnt_d = '0;
    end else if (drop_c) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + OVR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      rd_addr_q       <= '0;
      buf_id_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      ovr_cnt_q       <= '0;
    end else begin
      state_q         <= state_d;
      rd_addr_q       <= rd_addr_d;
      buf_id_q        <= buf_id_d;
      inflight_q      <= rd_en_c;
      inflight_last_q <= rd_en_c && (rd_addr_q == LAST_ADDR);
      frame_done_q    <= last_hs_c;
      overrun_q       <= overrun_d;
      ovr_cnt_q       <= ovr_cnt_d;
    end
  end

  // Output skid FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push_c) begin
        fifo_data_q[wr_ptr_q] <= rd_data_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
      end
    end
  end

  a_no_stray_rdata: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rd_data_valid_i |-> inflight_q);

  assign rd_en_o       = rd_en_c;
  assign rd_addr_o     = rd_addr_q;
  assign out_valid_o   = (fifo_cnt_q != '0);
  assign out_data_o    = fifo_data_q[rd_ptr_q];
  assign out_last_o    = out_valid_o && head_last_c;
  assign out_buf_id_o  = buf_id_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign frame_done_o  = frame_done_q;
  assign overrun_o     = overrun_q;
  assign overrun_cnt_o = ovr_cnt_q;

endmodule

// File: tb/tb_double_buffer_reader.sv
// Directed bench for double_buffer_reader with N=8, a 1-cycle RAM model and a
// beat log checked against hand-computed frames.
module tb_double_buffer_reader;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 8;

  logic          clk, rst_n;
  logic          pulse, pid, ready, clr;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic          out_valid, out_last, out_buf_id, busy, frame_done, overrun;
  logic [DW-1:0] out_data;
  logic [CW-1:0] ovr_cnt;
  logic [DW-1:0] base;

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
    bit            id;
    int            c;
  } beat_t;

  beat_t         beats[$];
  int            rd_cyc[$];
  int            cyc, n_chk, n_err;
  int            hold_viol, valid_err, addr_err, fd_cnt, occ, max_occ, issue_idx;
  bit            prev_stall, pl, pi;
  logic [DW-1:0] pd;
  int            t0;

  double_buffer_reader #(
    .DATA_WIDTH(DW), .SAMPLES_PER_BUF(N), .ADDR_WIDTH(AW),
    .FIFO_DEPTH(2), .OVR_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .buf_ready_pulse_i(pulse), .buf_ready_id_i(pid),
    .rd_addr_o(rd_addr), .rd_en_o(rd_en),
    .rd_data_i(rd_data), .rd_data_valid_i(rd_vld),
    .out_valid_o(out_valid), .out_ready_i(ready),
    .out_data_o(out_data), .out_last_o(out_last), .out_buf_id_o(out_buf_id),
    .busy_o(busy), .frame_done_o(frame_done),
    .overrun_o(overrun), .overrun_cnt_o(ovr_cnt), .clr_overrun_i(clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: word at address a is base + a, one cycle after the read
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_vld  <= rd_en;
      rd_data <= rd_en ? base + DW'(rd_addr) : '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    beats.delete();
    rd_cyc.delete();
    hold_viol = 0; valid_err = 0; addr_err = 0; fd_cnt = 0;
    occ = 0; max_occ = 0; issue_idx = 0; prev_stall = 1'b0;
  endtask

  // One cycle: drive inputs at negedge, then observe and log
  task automatic tick(input bit p, input bit id, input bit rdy, input bit c);
    @(negedge clk);
    pulse = p; pid = id; ready = rdy; clr = c;
    #1;
    cyc++;
    if (prev_stall && (!out_valid || out_data !== pd || out_last !== pl || out_buf_id !== pi))
      hold_viol++;
    prev_stall = out_valid && !ready;
    pd = out_data; pl = out_last; pi = out_buf_id;
    if ((occ != 0) != out_valid) valid_err++;
    if (occ > max_occ) max_occ = occ;
    if (out_valid && ready) beats.push_back('{out_data, out_last, out_buf_id, cyc});
    occ = occ + int'(rd_vld) - int'(out_valid && ready);
    if (rd_en) begin
      if (rd_addr !== AW'(issue_idx)) addr_err++;
      issue_idx = (issue_idx + 1) % N;
      rd_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
  endtask

  task automatic check_frame(input string tag, input int s, input logic [DW-1:0] b, input bit id);
    if (beats.size() < s + int'(N)) begin
      chk({tag, "_len"}, beats.size(), s + N);
      return;
    end
    for (int i = 0; i < int'(N); i++) begin
      chk({tag, "_data"}, beats[s+i].d, b + DW'(i));
      chk({tag, "_last"}, beats[s+i].l, (i == int'(N) - 1));
      chk({tag, "_id"}, beats[s+i].id, id);
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_hold"}, hold_viol, 0);
    chk({tag, "_valid"}, valid_err, 0);
    chk({tag, "_addr"}, addr_err, 0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    pulse = 0; pid = 0; ready = 0; clr = 0; base = '0;
    rst_n = 1'b0;
    clr_log();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", {overrun, ovr_cnt}, 0);
    chk("rst_misc", {out_data, out_last, out_buf_id, frame_done, rd_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1) basic frame, ready held high
    clr_log(); base = 16'h1000;
    tick(1, 1, 1, 0); t0 = cyc;
    repeat (13) tick(0, 0, 1, 0);
    chk("t1_beats", beats.size(), N);
    check_frame("t1", 0, base, 1);
    chk("t1_first_rd", rd_cyc[0] - t0, 1);
    chk("t1_first_beat", beats[0].c - t0, 3);
    chk("t1_last_beat", beats[N-1].c - t0, 10);
    chk("t1_reads", rd_cyc.size(), N);
    chk("t1_fdone", fd_cnt, 1);
    chk("t1_busy_end", busy, 0);
    check_stream("t1");

    // 2) ready toggling
    clr_log(); base = 16'h2000;
    tick(1, 0, 1, 0);
    for (int i = 0; i < 40; i++) tick(0, 0, i[0], 0);
    chk("t2_beats", beats.size(), N);
    check_frame("t2", 0, base, 0);
    chk("t2_occ_le2", (max_occ <= 2), 1);
    chk("t2_stall", ((rd_cyc[rd_cyc.size()-1] - rd_cyc[0] + 1) > int'(N)), 1);
    chk("t2_fdone", fd_cnt, 1);
    check_stream("t2");

    // 3) pulse mid-READ is dropped
    clr_log(); base = 16'h3000;
    tick(1, 0, 1, 0);
    repeat (3) tick(0, 0, 1, 0);
    tick(1, 1, 1, 0);
    tick(0, 0, 1, 0);
    chk("t3_ovr", overrun, 1);
    chk("t3_cnt", ovr_cnt, 1);
    repeat (8) tick(0, 0, 1, 0);
    check_frame("t3", 0, base, 0);
    chk("t3_fdone", fd_cnt, 1);
    tick(0, 0, 1, 1);
    tick(0, 0, 1, 0);
    chk("t3_clr", {overrun, ovr_cnt}, 0);
    check_stream("t3");

    // 4) pulse coincident with the last-beat handshake
    clr_log(); base = 16'h5000;
    tick(1, 0, 1, 0);
    repeat (9) tick(0, 0, 1, 0);
    tick(1, 1, 1, 0);
    chk("t4_last_now", out_last, 1);
    tick(0, 0, 1, 0);
    chk("t4_rd_en", rd_en, 1);
    chk("t4_addr0", rd_addr, 0);
    chk("t4_fdone_now", frame_done, 1);
    chk("t4_no_ovr", overrun, 0);
    repeat (12) tick(0, 0, 1, 0);
    chk("t4_beats", beats.size(), 2 * N);
    check_frame("t4a", 0, base, 0);
    check_frame("t4b", N, base, 1);
    if (beats.size() >= int'(2 * N)) chk("t4_gap", beats[N].c - beats[N-1].c, 3);
    chk("t4_cnt", ovr_cnt, 0);
    chk("t4_fdone", fd_cnt, 2);
    check_stream("t4");

    // 5) saturating overrun counter while the frame is stalled
    clr_log(); base = 16'h6000;
    tick(1, 0, 0, 0);
    repeat (10) tick(0, 0, 0, 0);
    chk("t5_occ_full", max_occ, 2);
    chk("t5_stalled_rd", rd_en, 0);
    for (int i = 0; i < 100; i++) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    chk("t5_cnt100", ovr_cnt, 100);
    for (int i = 0; i < 155; i++) begin tick(1, 0, 0, 0); tick(0, 0, 0, 0); end
    chk("t5_cnt255", ovr_cnt, 255);
    tick(1, 0, 0, 0); tick(0, 0, 0, 0);
    chk("t5_sat", ovr_cnt, 255);
    chk("t5_ovr", overrun, 1);
    chk("t5_busy", busy, 1);
    tick(1, 0, 0, 1); tick(0, 0, 0, 0);
    chk("t5_clr_prio", {overrun, ovr_cnt}, 0);
    repeat (14) tick(0, 0, 1, 0);
    check_frame("t5", 0, base, 0);
    chk("t5_fdone", fd_cnt, 1);
    check_stream("t5");

    // 6) reset mid-frame, then a fresh frame
    clr_log(); base = 16'h7000;
    tick(1, 1, 1, 0);
    repeat (6) tick(0, 0, 1, 0);
    chk("t6_beat3", out_data, 16'h7003);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_rd_en", rd_en, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_misc", {out_data, out_last, out_buf_id, frame_done, rd_addr}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clr_log(); base = 16'h4000;
    tick(1, 0, 1, 0); t0 = cyc;
    repeat (13) tick(0, 0, 1, 0);
    chk("t6_first_rd", rd_cyc[0] - t0, 1);
    check_frame("t6", 0, base, 0);
    chk("t6_fdone", fd_cnt, 1);
    check_stream("t6");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
